alu_input_sequencer: RTL and testbench
======================================

Name: alu_input_sequencer

Overview:
- Front-end stage directly upstream of the register/ALU/7-segment top level.
- Converts raw switch inputs and two raw push buttons (enter, undo) into the exact control stream the register stage consumes: registered data_out plus single-cycle load_A / load_B / load_Op strobes and the updateRes level.
- The operator steps through operand A, operand B, opcode and result display using a 4-state FSM.
- Buttons are synchronized and debounced locally.

Parameters:
- M, 16, width of switches and data_out; must match the register stage M.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button level change. Use 4 for simulation; the board build overrides it (e.g. 1000000). Minimum legal value is 2.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- switches  input  M  raw operand/opcode value from board switches.
- enter  input  1  raw, bouncy push button; advances the sequence.
- undo  input  1  raw, bouncy push button; steps the sequence back.
- data_out  output  M  registered copy of switches, captured on each accepted enter; drives data_in of the register stage.
- load_A  output  1  one-cycle strobe: data_out holds operand A.
- load_B  output  1  one-cycle strobe: data_out holds operand B.
- load_Op  output  1  one-cycle strobe: data_out holds the opcode.
- updateRes  output  1  level, high while in SHOW_RES.
- state_leds  output  4  one-hot current state, {SHOW_RES, WAIT_OP, WAIT_B, WAIT_A}.

Behaviour:
- Reset (reset==0 at a rising edge) sets:
  - state = WAIT_A, state_leds = 4'b0001
  - data_out = 0; load_A, load_B, load_Op, updateRes = 0
  - both synchronizer chains, debounced levels and debounce counters = 0
- Input conditioning, per button, identical for enter and undo:
  - Two-flop synchronizer feeds a debounced level db.
  - An internal counter increments on each edge where the synchronized value differs from db.
  - The counter clears to 0 on any edge where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, db toggles on that edge and the counter clears.
  - Press pulse = db & ~db_q, where db_q is db delayed one cycle. The pulse lasts exactly one cycle per debounced rising level.
  - Release produces no action. A held button yields exactly one pulse. A glitch shorter than DEBOUNCE_CYCLES cycles yields none.
- Latency: raw enter first sampled high at edge 0 → strobe high in the cycle after edge DEBOUNCE_CYCLES+3, for exactly one cycle.
- data_out is captured from switches on that same edge, so data_out and its strobe are valid together. data_out holds until the next accepted enter.
- FSM on an enter pulse (undo pulse absent):
  - WAIT_A → WAIT_B, assert load_A
  - WAIT_B → WAIT_OP, assert load_B
  - WAIT_OP → SHOW_RES, assert load_Op
  - SHOW_RES → WAIT_A, no strobe, data_out unchanged
- FSM on an undo pulse:
  - WAIT_B → WAIT_A
  - WAIT_OP → WAIT_B
  - SHOW_RES → WAIT_OP
  - WAIT_A → stays in WAIT_A
  - No strobe and no data_out change in any case.
- Enter and undo pulses in the same cycle: undo wins; enter is discarded, no strobe.
- updateRes = 1 exactly while state == SHOW_RES, registered together with the state.
- At most one of load_A / load_B / load_Op is high in any cycle. All strobes are low in every cycle without an accepted enter.
- Reset mid-debounce or mid-strobe: all outputs are 0 / WAIT_A on the next cycle.
- A button held through reset deassertion is treated as a new press and produces one pulse DEBOUNCE_CYCLES+3 edges after reset goes high.
- Switch changes between presses do not affect data_out.

Test Plan:
1. Reset low for 3 cycles, then high; enter held 10 cycles with switches=16'd4 (DEBOUNCE_CYCLES=4). Required: load_A high for exactly 1 cycle, 7 edges after enter is first sampled; data_out=4 in that cycle; state_leds=0010 afterwards.
2. Continue: two clean presses with switches=16'd17, then switches=16'd2. Required: load_B pulse with data_out=17, then load_Op pulse with data_out=2; updateRes=1 and state_leds=1000; no overlapping strobes.
3. enter bounce pattern 1,0,1,1,0 (each pulse shorter than 4 cycles), then stable low. Required: no strobe, state unchanged.
4. In WAIT_OP press undo. Required: state_leds=0010, no strobe, data_out unchanged. Press undo twice more: WAIT_A, then stays at WAIT_A.
5. enter and undo raised on the same cycle in WAIT_B. Required: state goes to WAIT_A, no load_B, data_out unchanged.
6. Assert reset for one cycle while in SHOW_RES with enter mid-debounce. Required: next cycle state_leds=0001, updateRes=0, data_out=0; enter must be re-debounced from scratch.

Source files
------------

// File: rtl/alu_input_sequencer_if.sv
// Bundles the switch/button inputs and register-stage control outputs of the ALU input sequencer.
// Pure wiring: no storage and no added latency.
// There is no backpressure; the consumer must take every strobe in the cycle it is asserted.
//
// Ports (signals):
//   switches   [M-1:0]  raw operand/opcode value from the board switches
//   enter, undo         raw push buttons
//   data_out   [M-1:0]  value captured on the last accepted enter
//   load_A/B/Op         one-cycle strobes that qualify data_out
//   updateRes           level, high while the result is shown
//   state_leds [3:0]    one-hot sequencer state
// Modports:
//   master  drives the buttons and switches (board side)
//   slave   is the sequencer itself
interface alu_input_sequencer_if #(
  parameter int M = 16
);
  logic [M-1:0] switches;
  logic         enter;
  logic         undo;
  logic [M-1:0] data_out;
  logic         load_A;
  logic         load_B;
  logic         load_Op;
  logic         updateRes;
  logic [3:0]   state_leds;

  modport master (
    output switches, enter, undo,
    input  data_out, load_A, load_B, load_Op, updateRes, state_leds
  );

  modport slave (
    input  switches, enter, undo,
    output data_out, load_A, load_B, load_Op, updateRes, state_leds
  );
endinterface

// File: rtl/alu_input_sequencer.sv
// Turns the switches and the raw enter/undo buttons into the load strobes, data word and result level used by the register stage.
// Latency: enter first sampled high at edge 0 produces its strobe in the cycle after edge DEBOUNCE_CYCLES+3.
// There is no backpressure; each strobe lasts one cycle, and data_out holds its value until the next accepted enter.
//
// Ports:
//   Clk    system clock, rising edge
//   reset  synchronous active-low reset
//   seq    alu_input_sequencer_if.slave: switches/enter/undo in; data_out, load_A/B/Op, updateRes, state_leds out
module alu_input_sequencer #(
  parameter int M               = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 Clk,
  input  logic                 reset,
  alu_input_sequencer_if.slave seq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The state encoding is one-hot, so it drives state_leds directly.
  typedef enum logic [3:0] {
    WAIT_A   = 4'b0001,
    WAIT_B   = 4'b0010,
    WAIT_OP  = 4'b0100,
    SHOW_RES = 4'b1000
  } state_t;

  state_t state_q, state_d;

  // Index 0 holds enter and index 1 holds undo, so both buttons pass through the same conditioning.
  logic [1:0]       sync1, sync2;
  logic [1:0]       db, db_q;
  logic [1:0]       press;
  logic [CNT_W-1:0] cnt [2];

  logic [2:0]       load_q, load_d;   // {load_Op, load_B, load_A}
  logic             capture;
  logic [M-1:0]     data_q;

  logic             enter_p, undo_p;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {seq.undo, seq.enter};
      sync2 <= sync1;
      db_q  <= db;
      // The press is registered so that the FSM sees it one edge after db_q settles.
      // This makes the latency exactly DEBOUNCE_CYCLES+3.
      press <= db & ~db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign enter_p = press[0];
  assign undo_p  = press[1];

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= WAIT_A;
      load_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      if (capture) data_q <= seq.switches;
    end
  end

  // When undo and enter are pressed together, undo takes priority and the enter is dropped.
  always_comb begin
    state_d = state_q;
    load_d  = '0;
    capture = 1'b0;
    if (undo_p) begin
      case (state_q)
        WAIT_B:   state_d = WAIT_A;
        WAIT_OP:  state_d = WAIT_B;
        SHOW_RES: state_d = WAIT_OP;
        default:  state_d = WAIT_A;
      endcase
    end else if (enter_p) begin
      case (state_q)
        WAIT_A: begin
          state_d = WAIT_B;
          load_d  = 3'b001;
          capture = 1'b1;
        end
        WAIT_B: begin
          state_d = WAIT_OP;
          load_d  = 3'b010;
          capture = 1'b1;
        end
        WAIT_OP: begin
          state_d = SHOW_RES;
          load_d  = 3'b100;
          capture = 1'b1;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  assign seq.data_out   = data_q;
  assign seq.load_A     = load_q[0];
  assign seq.load_B     = load_q[1];
  assign seq.load_Op    = load_q[2];
  assign seq.updateRes  = (state_q == SHOW_RES);
  assign seq.state_leds = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Testbench for alu_input_sequencer: directed scenarios, then randomized button and switch activity.
// A reference model predicts every output on every cycle.
// The model is written from the sequencing rules using history queues and simple arithmetic.
module tb_alu_input_sequencer;
  localparam int M  = 16;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_input_sequencer_if #(.M(M)) bus ();

  alu_input_sequencer #(.M(M), .DEBOUNCE_CYCLES(DC)) dut (
    .Clk   (clk),
    .reset (rst_n),
    .seq   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Reference model state.
  bit           he[$];
  bit           hu[$];
  bit           db_e, db_u;
  bit           e_d1, e_d2, u_d1, u_d2;
  int           st;          // 0=WAIT_A 1=WAIT_B 2=WAIT_OP 3=SHOW_RES
  logic [M-1:0] m_data;
  logic [2:0]   m_ld;

  // Monitor of observed strobes.
  int           la_cnt, lb_cnt, lo_cnt, la_first;
  logic [M-1:0] la_data, lb_data, lo_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The debounced level flips once the last DC synchronized samples all disagree with it.
  // A synchronized sample lags the raw input by two edges; samples from before reset count as 0.
  function automatic bit window_differs(input bit h[$], input bit db);
    int idx;
    bit s;
    for (int j = 0; j < DC; j++) begin
      idx = h.size() - 2 - j;
      s   = (idx >= 0) ? h[idx] : 1'b0;
      if (s == db) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit rise_e, rise_u, act_e, act_u;
    edge_n++;
    m_ld = '0;
    if (!rst_n) begin
      he.delete();
      hu.delete();
      db_e = 0; db_u = 0;
      e_d1 = 0; e_d2 = 0; u_d1 = 0; u_d2 = 0;
      st = 0;
      m_data = '0;
      return;
    end
    rise_e = 0;
    rise_u = 0;
    if (window_differs(he, db_e)) begin db_e = !db_e; rise_e = db_e; end
    if (window_differs(hu, db_u)) begin db_u = !db_u; rise_u = db_u; end
    he.push_back(bus.enter);
    hu.push_back(bus.undo);
    // A debounced rise takes effect at the FSM two edges later.
    act_e = e_d2; e_d2 = e_d1; e_d1 = rise_e;
    act_u = u_d2; u_d2 = u_d1; u_d1 = rise_u;
    if (act_u) begin
      if (st > 0) st--;
    end else if (act_e) begin
      if (st < 3) begin
        m_ld   = 3'(1 << st);
        m_data = bus.switches;
      end
      st = (st + 1) % 4;
    end
  endtask

  task automatic check_outputs();
    chk("state_leds", 32'(bus.state_leds), 32'(1 << st));
    chk("updateRes", 32'(bus.updateRes), 32'(st == 3));
    chk("strobes", 32'({bus.load_Op, bus.load_B, bus.load_A}), 32'(m_ld));
    chk("data_out", 32'(bus.data_out), 32'(m_data));
    chk("strobe_onehot0", 32'($onehot0({bus.load_Op, bus.load_B, bus.load_A})), 32'd1);
    if (bus.load_A) begin
      la_cnt++;
      la_data = bus.data_out;
      if (la_first < 0) la_first = edge_n;
    end
    if (bus.load_B)  begin lb_cnt++; lb_data = bus.data_out; end
    if (bus.load_Op) begin lo_cnt++; lo_data = bus.data_out; end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end
  endtask

  task automatic clear_mon();
    la_cnt = 0; lb_cnt = 0; lo_cnt = 0; la_first = -1;
    la_data = '0; lb_data = '0; lo_data = '0;
  endtask

  task automatic press_enter(input logic [M-1:0] sw);
    bus.switches = sw;
    bus.enter = 1'b1;
    step(8);
    bus.enter = 1'b0;
    step(8);
  endtask

  task automatic press_undo();
    bus.undo = 1'b1;
    step(8);
    bus.undo = 1'b0;
    step(8);
  endtask

  initial begin
    int t0;
    bit bounce [5];
    int hold;

    rst_n = 1'b0;
    bus.enter = 1'b0;
    bus.undo = 1'b0;
    bus.switches = '0;
    clear_mon();
    step(3);
    chk("reset_leds", 32'(bus.state_leds), 32'h1);
    chk("reset_data", 32'(bus.data_out), 32'h0);

    // Test 1: a held enter produces exactly one load_A, DC+3 edges after enter is first sampled.
    rst_n = 1'b1;
    step(2);
    clear_mon();
    bus.switches = 16'd4;
    bus.enter = 1'b1;
    t0 = edge_n + 1;
    step(10);
    bus.enter = 1'b0;
    step(10);
    chk("t1_latency", 32'(la_first - t0), 32'(DC + 3));
    chk("t1_count", 32'(la_cnt), 32'd1);
    chk("t1_data", 32'(la_data), 32'd4);
    chk("t1_leds", 32'(bus.state_leds), 32'b0010);

    // Test 2: load operand B, then the opcode.
    clear_mon();
    press_enter(16'd17);
    press_enter(16'd2);
    chk("t2_ldb_cnt", 32'(lb_cnt), 32'd1);
    chk("t2_ldb_data", 32'(lb_data), 32'd17);
    chk("t2_ldop_cnt", 32'(lo_cnt), 32'd1);
    chk("t2_ldop_data", 32'(lo_data), 32'd2);
    chk("t2_upd", 32'(bus.updateRes), 32'd1);
    chk("t2_leds", 32'(bus.state_leds), 32'b1000);

    // Test 3: a bounce made of short glitches produces nothing.
    clear_mon();
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.enter = bounce[i];
      step(1);
    end
    bus.enter = 1'b0;
    step(10);
    chk("t3_strobes", 32'(la_cnt + lb_cnt + lo_cnt), 32'd0);
    chk("t3_leds", 32'(bus.state_leds), 32'b1000);

    // Test 4: undo steps back, and stops at WAIT_A.
    clear_mon();
    press_undo();
    chk("t4_leds_op", 32'(bus.state_leds), 32'b0100);
    press_undo();
    chk("t4_leds_b", 32'(bus.state_leds), 32'b0010);
    press_undo();
    chk("t4_leds_a", 32'(bus.state_leds), 32'b0001);
    press_undo();
    chk("t4_leds_a2", 32'(bus.state_leds), 32'b0001);
    chk("t4_strobes", 32'(la_cnt + lb_cnt + lo_cnt), 32'd0);
    chk("t4_data", 32'(bus.data_out), 32'd2);

    // Test 5: pressing enter and undo together in WAIT_B is an undo.
    press_enter(16'd9);
    clear_mon();
    bus.switches = 16'h0055;
    bus.enter = 1'b1;
    bus.undo = 1'b1;
    step(8);
    bus.enter = 1'b0;
    bus.undo = 1'b0;
    step(8);
    chk("t5_leds", 32'(bus.state_leds), 32'b0001);
    chk("t5_ldb", 32'(lb_cnt), 32'd0);
    chk("t5_data", 32'(bus.data_out), 32'd9);

    // Test 6: reset while in SHOW_RES with enter half debounced; a held enter is then debounced again from the start.
    press_enter(16'h0011);
    press_enter(16'h0022);
    press_enter(16'h0033);
    chk("t6_pre_leds", 32'(bus.state_leds), 32'b1000);
    bus.enter = 1'b1;
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("t6_leds", 32'(bus.state_leds), 32'b0001);
    chk("t6_upd", 32'(bus.updateRes), 32'd0);
    chk("t6_data", 32'(bus.data_out), 32'd0);
    rst_n = 1'b1;
    clear_mon();
    t0 = edge_n + 1;
    step(12);
    bus.enter = 1'b0;
    step(8);
    chk("t6_latency", 32'(la_first - t0), 32'(DC + 3));
    chk("t6_count", 32'(la_cnt), 32'd1);

    // Randomized activity, including occasional resets.
    for (int seg = 0; seg < 120; seg++) begin
      hold = $urandom_range(10, 1);
      if ($urandom_range(40, 0) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      bus.enter    = 1'($urandom_range(1, 0));
      bus.undo     = 1'($urandom_range(1, 0));
      bus.switches = M'($urandom);
      step(hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
